// File: rtl/serial_mod_detector.sv
// Serial modulo-DIVISOR detector: consumes one framed bit per accepted cycle and
// keeps the running remainder, a divisibility flag, a bit count and a done pulse.
module serial_mod_detector #(
  parameter int DIVISOR   = 3,
  parameter bit LSB_FIRST = 1'b0,
  parameter int CNT_W     = 8,
  localparam int RW       = $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_first,
  input  logic             in_last,
  output logic [RW-1:0]    rem,
  output logic             divisible,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             busy,
  output logic             done
);

  if (DIVISOR < 2) begin : g_bad_divisor
    $error("serial_mod_detector: DIVISOR must be >= 2");
  end

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [RW:0]      DIV     = (RW+1)'(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t        state, state_nx;
  logic [RW-1:0] weight;
  logic [RW-1:0] base_r, base_w, r_nx, w_nx;
  logic [RW:0]   sum, dbl_w;
  logic          accept, new_num;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    accept  = in_valid && !clr;
    new_num = (state == IDLE) || in_first;
    base_r  = new_num ? '0 : rem;
    base_w  = new_num ? RW'(1) : weight;

    // Both operands are below DIVISOR, so the sum is below 2*DIVISOR: one subtract suffices.
    if (LSB_FIRST) sum = {1'b0, base_r} + (in_bit ? {1'b0, base_w} : '0);
    else           sum = {base_r, in_bit};
    r_nx  = (sum >= DIV) ? RW'(sum - DIV) : sum[RW-1:0];

    // For even DIVISOR the weight can collapse to 0 and stay there; that is harmless.
    dbl_w = {base_w, 1'b0};
    w_nx  = (dbl_w >= DIV) ? RW'(dbl_w - DIV) : dbl_w[RW-1:0];

    state_nx = state;
    if (clr) begin
      state_nx = IDLE;
    end else if (accept) begin
      state_nx = in_last ? IDLE : ACTIVE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem       <= '0;
      divisible <= 1'b0;
      bit_cnt   <= '0;
      weight    <= RW'(1);
      done      <= 1'b0;
    end else if (clr) begin
      rem       <= '0;
      divisible <= 1'b0;
      bit_cnt   <= '0;
      weight    <= RW'(1);
      done      <= 1'b0;
    end else begin
      done <= in_valid && in_last;
      if (in_valid) begin
        rem       <= r_nx;
        divisible <= (r_nx == '0);
        weight    <= w_nx;
        if (new_num)               bit_cnt <= CNT_W'(1);
        else if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign busy = (state == ACTIVE);

endmodule
